booth_r4_mult_pipe: RTL and testbench

//  Parametrised radix-4 Booth multiplier, pipelined, with valid/ready handshake on input and output.

---
 rtl/booth_pkg.sv | 53 +++++
 rtl/booth_r4_mult_pipe_stage.sv | 62 ++++++
 rtl/booth_r4_mult_pipe.sv | 113 +++++++++++
 tb/tb_booth_r4_mult_pipe.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared constants and helpers for the pipelined radix-4 Booth multiplier.
// Digit encoding is sign-magnitude: bit 2 = negate, bits 1:0 = magnitude (0, 1, 2).
package booth_pkg;

    // Widest operand the helper functions support. The module's own WIDTH must not exceed it.
    localparam int unsigned MAX_WIDTH = 128;
    localparam int unsigned PP_W      = 2 * MAX_WIDTH + 2;
    localparam int unsigned DIG_W     = 3;

    typedef logic [PP_W-1:0] pp_t;

    typedef enum logic [2:0] {
        DigZero = 3'b000,
        DigP1   = 3'b001,
        DigP2   = 3'b010,
        DigM1   = 3'b101,
        DigM2   = 3'b110
    } booth_digit_e;

    function automatic int unsigned npp(int unsigned width);
        return width / 2 + 1;
    endfunction

    function automatic int unsigned n_stages(int unsigned width, int unsigned pp_per_stage);
        return (npp(width) + pp_per_stage - 1) / pp_per_stage;
    endfunction

    // Recode one overlapping triplet {b[2i+1], b[2i], b[2i-1]} into a Booth digit.
    function automatic logic [2:0] booth_recode(logic [2:0] trip);
        case (trip)
            3'b001, 3'b010: return DigP1;
            3'b011:         return DigP2;
            3'b100:         return DigM2;
            3'b101, 3'b110: return DigM1;
            default:        return DigZero;
        endcase
    endfunction

    // a_ext must already be sign-extended to PP_W; result is the weighted partial product.
    function automatic pp_t booth_pp(pp_t a_ext, logic [2:0] digit, int unsigned index);
        pp_t mag;
        case (digit)
            DigP1, DigM1: mag = a_ext;
            DigP2, DigM2: mag = a_ext << 1;
            default:      mag = '0;
        endcase
        if (digit[2]) begin
            mag = -mag;
        end
        return mag << (2 * index);
    endfunction

endpackage

// File: rtl/booth_r4_mult_pipe_stage.sv
// One accumulation stage of the Booth pipeline: adds its slice of partial products to the
// running sum and forwards operands, digits, tag and valid. Holds everything when en is low.
module booth_r4_stage
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned PP_PER_STAGE = 4,
    parameter int unsigned TAG_W        = 4,
    parameter int unsigned STAGE_IDX    = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          prev_valid,
    input  logic [2*WIDTH+1:0]            prev_sum,
    input  logic [WIDTH+1:0]              prev_a,
    input  logic [3*(WIDTH/2+1)-1:0]      prev_digits,
    input  logic [TAG_W-1:0]              prev_tag,
    output logic                          valid,
    output logic [2*WIDTH+1:0]            sum,
    output logic [WIDTH+1:0]              a_ext,
    output logic [3*(WIDTH/2+1)-1:0]      digits,
    output logic [TAG_W-1:0]              tag
);

    localparam int unsigned NPP   = npp(WIDTH);
    localparam int unsigned SUM_W = 2 * WIDTH + 2;
    localparam int unsigned FIRST = STAGE_IDX * PP_PER_STAGE;

    logic [SUM_W-1:0] acc;
    int unsigned      idx;

    always_comb begin
        acc = prev_sum;
        idx = 0;
        for (int unsigned j = 0; j < PP_PER_STAGE; j++) begin
            // The last stage may own fewer than PP_PER_STAGE digits.
            idx = (FIRST + j < NPP) ? FIRST + j : 0;
            if (FIRST + j < NPP) begin
                acc = acc + SUM_W'(booth_pp(pp_t'($signed(prev_a)),
                                            prev_digits[DIG_W*idx +: DIG_W], idx));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid  <= 1'b0;
            sum    <= '0;
            a_ext  <= '0;
            digits <= '0;
            tag    <= '0;
        end else if (en) begin
            valid  <= prev_valid;
            sum    <= acc;
            a_ext  <= prev_a;
            digits <= prev_digits;
            tag    <= prev_tag;
        end
    end

endmodule

// File: rtl/booth_r4_mult_pipe.sv
// Pipelined radix-4 Booth multiplier with valid/ready on both sides and a global stall.
// Define BOOTH_UNSIGNED_EN to add the per-operation in_signed port; otherwise all ops are signed.
module booth_r4_mult_pipe
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned PP_PER_STAGE = 4,
    parameter int unsigned TAG_W        = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [TAG_W-1:0]     in_tag,
`ifdef BOOTH_UNSIGNED_EN
    input  logic                 in_signed,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_product,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int unsigned NPP    = npp(WIDTH);
    localparam int unsigned N      = n_stages(WIDTH, PP_PER_STAGE);
    localparam int unsigned SUM_W  = 2 * WIDTH + 2;
    localparam int unsigned EXT_W  = WIDTH + 2;
    localparam int unsigned DIGS_W = DIG_W * NPP;

    logic              advance;
    logic              is_signed;
    logic [EXT_W-1:0]  a_ext;
    logic [EXT_W-1:0]  b_ext;
    logic [EXT_W:0]    b_pad;
    logic [DIGS_W-1:0] digits;

    logic              stg_valid  [N+1];
    logic [SUM_W-1:0]  stg_sum    [N+1];
    logic [EXT_W-1:0]  stg_a      [N+1];
    logic [DIGS_W-1:0] stg_digits [N+1];
    logic [TAG_W-1:0]  stg_tag    [N+1];

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

`ifdef BOOTH_UNSIGNED_EN
    assign is_signed = in_signed;
`else
    assign is_signed = 1'b1;
`endif

    // Signedness is folded into the extension here, so it travels with the op implicitly.
    assign a_ext = {{2{is_signed & in_a[WIDTH-1]}}, in_a};
    assign b_ext = {{2{is_signed & in_b[WIDTH-1]}}, in_b};

    always_comb begin
        b_pad  = {b_ext, 1'b0};
        digits = '0;
        for (int unsigned i = 0; i < NPP; i++) begin
            digits[DIG_W*i +: DIG_W] = booth_recode(b_pad[2*i +: 3]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stg_valid[0]  <= 1'b0;
            stg_a[0]      <= '0;
            stg_digits[0] <= '0;
            stg_tag[0]    <= '0;
        end else if (advance) begin
            stg_valid[0]  <= in_valid;
            stg_a[0]      <= a_ext;
            stg_digits[0] <= digits;
            stg_tag[0]    <= in_tag;
        end
    end

    assign stg_sum[0] = '0;

    for (genvar k = 1; k <= N; k++) begin : g_stage
        booth_r4_stage #(
            .WIDTH        (WIDTH),
            .PP_PER_STAGE (PP_PER_STAGE),
            .TAG_W        (TAG_W),
            .STAGE_IDX    (k - 1)
        ) u_stage (
            .clk         (clk),
            .rst         (rst),
            .en          (advance),
            .prev_valid  (stg_valid[k-1]),
            .prev_sum    (stg_sum[k-1]),
            .prev_a      (stg_a[k-1]),
            .prev_digits (stg_digits[k-1]),
            .prev_tag    (stg_tag[k-1]),
            .valid       (stg_valid[k]),
            .sum         (stg_sum[k]),
            .a_ext       (stg_a[k]),
            .digits      (stg_digits[k]),
            .tag         (stg_tag[k])
        );
    end

    assign out_valid   = stg_valid[N];
    assign out_product = stg_sum[N][2*WIDTH-1:0];
    assign out_tag     = stg_tag[N];

    // The exact product fits in 2*WIDTH bits; the guard bits and forwarded operands end here.
    logic unused_tail;
    assign unused_tail = ^{stg_sum[N][SUM_W-1:2*WIDTH], stg_a[N], stg_digits[N]};

endmodule

// File: tb/tb_booth_r4_mult_pipe.sv
// Self-checking bench for booth_r4_mult_pipe (WIDTH=32, PP_PER_STAGE=4, latency 6).
module tb_booth_r4_mult_pipe;

    localparam int unsigned W  = 32;
    localparam int unsigned TW = 4;

    typedef struct {
        logic [2*W-1:0] p;
        logic [TW-1:0]  t;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b1;
    logic           sgn = 1'b1;
    logic [W-1:0]   in_a = '0;
    logic [W-1:0]   in_b = '0;
    logic [TW-1:0]  in_tag = '0;
    logic           in_ready;
    logic           out_valid;
    logic [2*W-1:0] out_product;
    logic [TW-1:0]  out_tag;

    booth_r4_mult_pipe #(
        .WIDTH        (W),
        .PP_PER_STAGE (4),
        .TAG_W        (TW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_tag      (in_tag),
`ifdef BOOTH_UNSIGNED_EN
        .in_signed   (sgn),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .out_tag     (out_tag)
    );

    always #5 clk = ~clk;

    exp_t           exp_q[$];
    exp_t           cur_exp;
    int             n_checks = 0;
    int             n_pass = 0;
    bit             in_fire = 1'b0;
    bit             hold_pending = 1'b0;
    bit             rand_ready = 1'b0;
    logic [2*W-1:0] held_p;
    logic [TW-1:0]  held_t;
    int             cyc = 0;
    int             pops = 0;
    int             first_pop = -1;
    int             last_pop = -1;
    int             lat;

    function automatic logic [2*W-1:0] model(logic [W-1:0] a, logic [W-1:0] b, logic s);
        if (s) return 64'(longint'($signed(a)) * longint'($signed(b)));
        return {32'b0, a} * {32'b0, b};
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", name, obs, expv);
    endtask

    // One clock: sample handshakes at the falling edge, then advance past the rising edge.
    task automatic step();
        exp_t e;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        if (hold_pending) begin
            check("hold_product", out_product, held_p);
            check("hold_tag", 64'(out_tag), 64'(held_t));
        end
        hold_pending = out_valid && !out_ready && !rst;
        held_p = out_product;
        held_t = out_tag;
        if (out_valid && out_ready && !rst) begin
            if (exp_q.size() == 0) begin
                check("spurious_result", 64'(out_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("product", out_product, e.p);
                check("tag", 64'(out_tag), 64'(e.t));
                pops++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
        end
        in_fire = in_valid && in_ready && !rst;
        if (in_fire) exp_q.push_back(cur_exp);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] t,
                        input logic s, input logic [2*W-1:0] p);
        in_a = a;
        in_b = b;
        in_tag = t;
        sgn = s;
        cur_exp.p = p;
        cur_exp.t = t;
        in_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            step();
            if (in_fire) return;
        end
        check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_rand(input logic [TW-1:0] t);
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        a = $urandom();
        b = $urandom();
`ifdef BOOTH_UNSIGNED_EN
        s = 1'($urandom_range(0, 1));
`else
        s = 1'b1;
`endif
        send(a, b, t, s, model(a, b, s));
    endtask

    task automatic drain();
        in_valid = 1'b0;
        rand_ready = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        step();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_product", out_product, 64'd0);
        check("reset_out_tag", 64'(out_tag), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);

        // Single op: result must appear exactly 6 cycles after acceptance.
        send(32'd10, 32'd20, 4'd5, 1'b1, 64'd200);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check("latency", 64'(lat), 64'd6);
        drain();

        // Arithmetic corners.
        send(32'h8000_0000, 32'hFFFF_FFFF, 4'd1, 1'b1, 64'd2147483648);
        send(32'h8000_0001, 32'h8000_0001, 4'd2, 1'b1, 64'h3FFF_FFFF_0000_0001);
        send(-32'sd15, 32'd30, 4'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FE3E);
        send(32'h8000_0000, 32'h8000_0000, 4'd4, 1'b1, 64'h4000_0000_0000_0000);
`ifdef BOOTH_UNSIGNED_EN
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd6, 1'b0, 64'hFFFF_FFFE_0000_0001);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd7, 1'b1, 64'd1);
`endif
        drain();

        // Eight back-to-back ops must emerge on eight consecutive cycles.
        pops = 0;
        first_pop = -1;
        for (int i = 0; i < 8; i++) send_rand(TW'(i));
        drain();
        check("stream_count", 64'(pops), 64'd8);
        check("stream_consecutive", 64'(last_pop - first_pop), 64'd7);

        // Fill the pipe with the consumer stalled, then hold for three cycles.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send_rand(TW'(8 + i));
        in_a = 32'd7;
        in_b = 32'd9;
        in_tag = 4'd14;
        cur_exp.p = 64'd63;
        cur_exp.t = 4'd14;
        sgn = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            step();
        end
        out_ready = 1'b1;
        send(32'd7, 32'd9, 4'd14, 1'b1, 64'd63);
        drain();

        // Reset with four ops in flight: none may emerge.
        for (int i = 0; i < 4; i++) send_rand(TW'(i));
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 10; i++) begin
            check("post_reset_valid", 64'(out_valid), 64'd0);
            step();
        end

        // Random operands with random consumer backpressure and input gaps.
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send_rand(TW'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                step();
            end
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
